// File: rtl/velocity_init.sv
`default_nettype none
// ============================================================================
// Module   : velocity_init
// Purpose  : Walks every lattice node once and writes an initial (ux, uy)
//            velocity drawn from two upstream Gaussian generators.
//            Optional macro VELINIT_CLAMP_EN saturates samples to +/-UMAX
//            and counts clamped components on clamp_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module velocity_init #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NX         = 16,
   parameter int                    NY         = 16,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] UMAX       = 32'h0004_0000
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] ux_rand_i,
   input  logic [DATA_WIDTH-1:0] uy_rand_i,
   output logic                  gen_enable_o,
   output logic                  wr_valid_o,
   input  logic                  wr_ready_i,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_ux_o,
   output logic [DATA_WIDTH-1:0] wr_uy_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef VELINIT_CLAMP_EN
   ,
   output logic [15:0]           clamp_count_o
`endif
);

   localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(NX * NY - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADVANCE = 3'd1,
      S_CAPTURE = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [DATA_WIDTH-1:0]   ux_q,    ux_d;
   logic [DATA_WIDTH-1:0]   uy_q,    uy_d;
   logic [DATA_WIDTH-1:0]   ux_samp, uy_samp;
   logic                    start_acc, handshake;

   assign start_acc = (state_q == S_IDLE) && start_i;
   assign handshake = (state_q == S_WRITE) && wr_ready_i;

`ifdef VELINIT_CLAMP_EN
   localparam logic signed [DATA_WIDTH-1:0] C_POS_LIM = $signed(UMAX);
   localparam logic signed [DATA_WIDTH-1:0] C_NEG_LIM = -$signed(UMAX);

   logic        ux_hi, ux_lo, uy_hi, uy_lo;
   logic [16:0] cnt_sum;
   logic [15:0] cnt_q, cnt_d;

   assign ux_hi = $signed(ux_rand_i) > C_POS_LIM;
   assign ux_lo = $signed(ux_rand_i) < C_NEG_LIM;
   assign uy_hi = $signed(uy_rand_i) > C_POS_LIM;
   assign uy_lo = $signed(uy_rand_i) < C_NEG_LIM;

   assign ux_samp = ux_hi ? C_POS_LIM : (ux_lo ? C_NEG_LIM : ux_rand_i);
   assign uy_samp = uy_hi ? C_POS_LIM : (uy_lo ? C_NEG_LIM : uy_rand_i);
   assign cnt_sum = {1'b0, cnt_q} + 17'(ux_hi | ux_lo) + 17'(uy_hi | uy_lo);

   always_comb begin
      cnt_d = cnt_q;
      if (start_acc) begin
         cnt_d = 16'h0000;
      end else if (state_q == S_CAPTURE) begin
         cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign clamp_count_o = cnt_q;
`else
   // UMAX only matters to the clamp build; this tie-off generates no hardware.
   logic unused_umax;
   assign unused_umax = ^UMAX;
   assign ux_samp     = ux_rand_i;
   assign uy_samp     = uy_rand_i;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_i) state_d = S_ADVANCE;
         S_ADVANCE: state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_WRITE;
         S_WRITE: begin
            if (wr_ready_i) begin
               state_d = (addr_q == C_LAST_ADDR) ? S_DONE : S_ADVANCE;
            end
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The counter holds at the last address through DONE; only Start clears it.
   always_comb begin
      addr_d = addr_q;
      ux_d   = ux_q;
      uy_d   = uy_q;
      if (start_acc) begin
         addr_d = '0;
      end else if (handshake && (addr_q != C_LAST_ADDR)) begin
         addr_d = addr_q + 1'b1;
      end
      if (state_q == S_CAPTURE) begin
         ux_d = ux_samp;
         uy_d = uy_samp;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         addr_q <= '0;
         ux_q   <= '0;
         uy_q   <= '0;
      end else begin
         addr_q <= addr_d;
         ux_q   <= ux_d;
         uy_q   <= uy_d;
      end
   end

   assign gen_enable_o = (state_q == S_ADVANCE);
   assign wr_valid_o   = (state_q == S_WRITE);
   assign busy_o       = (state_q == S_ADVANCE) || (state_q == S_CAPTURE) ||
                         (state_q == S_WRITE);
   assign done_o       = (state_q == S_DONE);
   assign wr_addr_o    = addr_q;
   assign wr_ux_o      = ux_q;
   assign wr_uy_o      = uy_q;

endmodule
`default_nettype wire

// File: tb/tb_velocity_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_velocity_init
// Purpose  : Directed, table-driven self-checking bench for velocity_init
//            on a 4x4 lattice (also covers the VELINIT_CLAMP_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_velocity_init;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset, start, wr_ready;
   logic [DW-1:0] ux_rand, uy_rand;
   logic          gen_enable, wr_valid, busy, done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_ux, wr_uy;
`ifdef VELINIT_CLAMP_EN
   logic [15:0]   clamp_count;
`endif

   always #5 clk = ~clk;

   velocity_init #(
      .DATA_WIDTH (DW),
      .NX         (4),
      .NY         (4),
      .ADDR_WIDTH (AW),
      .UMAX       (32'h0004_0000)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .ux_rand_i    (ux_rand),
      .uy_rand_i    (uy_rand),
      .gen_enable_o (gen_enable),
      .wr_valid_o   (wr_valid),
      .wr_ready_i   (wr_ready),
      .wr_addr_o    (wr_addr),
      .wr_ux_o      (wr_ux),
      .wr_uy_o      (wr_uy),
      .busy_o       (busy),
      .done_o       (done)
`ifdef VELINIT_CLAMP_EN
      ,
      .clamp_count_o(clamp_count)
`endif
   );

   // Raw samples, their clamped images for UMAX=0x0004_0000, and clip count.
   typedef struct {
      logic [31:0] ux;
      logic [31:0] uy;
      logic [31:0] cux;
      logic [31:0] cuy;
      int          clips;
   } vec_t;

   vec_t vecs [8];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_ux(input int n);
`ifdef VELINIT_CLAMP_EN
      return vecs[n % 8].cux;
`else
      return vecs[n % 8].ux;
`endif
   endfunction

   function automatic logic [31:0] exp_uy(input int n);
`ifdef VELINIT_CLAMP_EN
      return vecs[n % 8].cuy;
`else
      return vecs[n % 8].uy;
`endif
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, " gen_enable"}, gen_enable, 0);
      check({tag, " wr_valid"},   wr_valid,   0);
      check({tag, " busy"},       busy,       0);
      check({tag, " done"},       done,       0);
      check({tag, " wr_addr"},    wr_addr,    0);
      check({tag, " wr_ux"},      wr_ux,      0);
      check({tag, " wr_uy"},      wr_uy,      0);
`ifdef VELINIT_CLAMP_EN
      check({tag, " clamp_count"}, clamp_count, 0);
`endif
   endtask

   // One full lattice run; optional stall, mid-run reset, or stray Start at node n.
   task automatic run(input string tag, input int stall_at, input int reset_at,
                      input int restart_at);
      int clips;
      clips = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         check($sformatf("%s adv gen_enable n=%0d", tag, n), gen_enable, 1);
         check($sformatf("%s adv wr_valid n=%0d", tag, n), wr_valid, 0);
         check($sformatf("%s adv busy n=%0d", tag, n), busy, 1);
         ux_rand = vecs[n % 8].ux;
         uy_rand = vecs[n % 8].uy;
         if (n == restart_at) start = 1'b1;
         tick();
         start = 1'b0;
         check($sformatf("%s cap gen_enable n=%0d", tag, n), gen_enable, 0);
         tick();
         check($sformatf("%s wr_valid n=%0d", tag, n), wr_valid, 1);
         check($sformatf("%s wr_addr n=%0d", tag, n), wr_addr, n);
         check($sformatf("%s wr_ux n=%0d", tag, n), wr_ux, exp_ux(n));
         check($sformatf("%s wr_uy n=%0d", tag, n), wr_uy, exp_uy(n));
         clips += vecs[n % 8].clips;
         ux_rand = ~ux_rand;
         uy_rand = ~uy_rand;
         if (n == reset_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_reset_state($sformatf("%s midrun reset", tag));
            tick();
            check_reset_state($sformatf("%s idle after reset", tag));
            return;
         end
         if (n == stall_at) begin
            wr_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               tick();
               check($sformatf("%s stall wr_valid i=%0d", tag, i), wr_valid, 1);
               check($sformatf("%s stall wr_addr i=%0d", tag, i), wr_addr, n);
               check($sformatf("%s stall wr_ux i=%0d", tag, i), wr_ux, exp_ux(n));
               check($sformatf("%s stall wr_uy i=%0d", tag, i), wr_uy, exp_uy(n));
               check($sformatf("%s stall gen_enable i=%0d", tag, i), gen_enable, 0);
            end
            wr_ready = 1'b1;
         end
         tick();
      end
      check({tag, " done pulse"}, done, 1);
      check({tag, " busy at done"}, busy, 0);
      check({tag, " wr_valid at done"}, wr_valid, 0);
`ifdef VELINIT_CLAMP_EN
      check({tag, " clamp_count"}, clamp_count, clips);
`endif
      tick();
      check({tag, " done drops"}, done, 0);
      check({tag, " busy after"}, busy, 0);
      tick();
      check({tag, " no second done"}, done, 0);
      check({tag, " idle gen_enable"}, gen_enable, 0);
   endtask

   initial begin
      vecs[0] = '{32'h0010_0000, 32'hFFF0_0000, 32'h0004_0000, 32'hFFFC_0000, 2};
      vecs[1] = '{32'hFFFD_F3B7, 32'h0001_0000, 32'hFFFD_F3B7, 32'h0001_0000, 0};
      vecs[2] = '{32'h0004_0000, 32'hFFFC_0000, 32'h0004_0000, 32'hFFFC_0000, 0};
      vecs[3] = '{32'h0004_0001, 32'hFFFB_FFFF, 32'h0004_0000, 32'hFFFC_0000, 2};
      vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0004_0000, 32'hFFFC_0000, 2};
      vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};
      vecs[6] = '{32'h0003_FFFF, 32'h0123_4567, 32'h0003_FFFF, 32'h0004_0000, 1};
      vecs[7] = '{32'hFFFC_0001, 32'h0000_0001, 32'hFFFC_0001, 32'h0000_0001, 0};

      reset    = 1'b1;
      start    = 1'b0;
      wr_ready = 1'b1;
      ux_rand  = 32'h1234_5678;
      uy_rand  = 32'h9ABC_DEF0;
      tick();
      tick();
      check_reset_state("reset");
      reset = 1'b0;
      tick();
      check_reset_state("idle");

      run("plain",   -1, -1, -1);
      run("stall",    3, -1, -1);
      run("reset",   -1,  7, -1);
      run("restart", -1, -1,  5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
